// File: rtl/uop_ecdsa_pkg.sv
// uop_ecdsa_pkg: shared opcode, selector, exec codes, field positions and FSM states for the uop sequencer
package uop_ecdsa_pkg;
  localparam logic [3:0] OPCODE_MOV = 4'h1;
  localparam logic [3:0] OPCODE_ADD = 4'h2;
  localparam logic [3:0] OPCODE_SUB = 4'h3;
  localparam logic [3:0] OPCODE_MUL = 4'h4;
  localparam logic [3:0] OPCODE_CMP = 4'h5;
  localparam logic [3:0] OPCODE_RDY = 4'hF;
  localparam logic [3:0] UOP_SRC_PX   = 4'h0;
  localparam logic [3:0] UOP_SRC_PY   = 4'h1;
  localparam logic [3:0] UOP_SRC_PZ   = 4'h2;
  localparam logic [3:0] UOP_SRC_QX   = 4'h3;
  localparam logic [3:0] UOP_SRC_QY   = 4'h4;
  localparam logic [3:0] UOP_SRC_T1   = 4'h9;
  localparam logic [3:0] UOP_SRC_T2   = 4'hA;
  localparam logic [3:0] UOP_SRC_ZERO = 4'hD;
  localparam logic [3:0] UOP_SRC_ONE  = 4'hE;
  localparam logic [3:0] UOP_DST_RX   = 4'h6;
  localparam logic [3:0] UOP_DST_RY   = 4'h7;
  localparam logic [3:0] UOP_DST_RZ   = 4'h8;
  localparam logic [3:0] UOP_DST_T1   = 4'h9;
  localparam logic [3:0] UOP_DST_T2   = 4'hA;
  localparam logic [3:0] UOP_EXEC_ALWAYS = 4'h0;
  localparam logic [3:0] UOP_EXEC_IF_EQ  = 4'h1;
  localparam int OP_LSB   = 16;
  localparam int SRC1_LSB = 12;
  localparam int SRC2_LSB = 8;
  localparam int DST_LSB  = 4;
  localparam int EXEC_LSB = 0;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT, S_DONE} seq_state_t;
endpackage

// File: rtl/uop_sequencer_if.sv
// uop_sequencer_if: microcode ROM port and datapath issue/completion handshake
interface uop_sequencer_if #(parameter int ADDR_W = 6, parameter int UOP_W = 20);
  logic [ADDR_W-1:0] rom_addr;
  logic [UOP_W-1:0]  rom_data;
  logic              uop_valid;
  logic [3:0]        uop_opcode;
  logic [3:0]        uop_src1;
  logic [3:0]        uop_src2;
  logic [3:0]        uop_dst;
  logic              uop_done;
  logic              cmp_eq;
  modport master (output rom_addr, uop_valid, uop_opcode, uop_src1, uop_src2, uop_dst,
                  input rom_data, uop_done, cmp_eq);
  modport slave (input rom_addr, uop_valid, uop_opcode, uop_src1, uop_src2, uop_dst,
                 output rom_data, uop_done, cmp_eq);
endinterface

// File: rtl/uop_seq_watchdog.sv
// uop_seq_watchdog: 16-bit WAIT-cycle counter, expires when it has counted 0xFFFF cycles
module uop_seq_watchdog (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [15:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : inc ? cnt + 16'd1 : cnt;
  assign expired = inc && (&cnt);
endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: microcode fetch/decode/issue FSM; UOP_SEQ_WATCHDOG_EN adds a WAIT timeout driving sticky err
module uop_sequencer
  import uop_ecdsa_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int UOP_W    = 20,
  parameter int MAX_ADDR = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  output logic             rdy,
  output logic             err,
  uop_sequencer_if.master  bus
);
  seq_state_t       st;
  logic             flag_eq;
  logic             wd_to;
  logic [UOP_W-1:0] w;
  logic [3:0]       op, exec;
  logic             run, last;
  assign w    = bus.rom_data;
  assign op   = w[OP_LSB+:4];
  assign exec = w[EXEC_LSB+:4];
  assign run  = (exec != UOP_EXEC_IF_EQ) || flag_eq;
  assign last = bus.rom_addr == ADDR_W'(MAX_ADDR);
  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= S_IDLE;
      rdy            <= 1'b1;
      flag_eq        <= 1'b0;
      bus.rom_addr   <= '0;
      bus.uop_valid  <= 1'b0;
      bus.uop_opcode <= '0;
      bus.uop_src1   <= '0;
      bus.uop_src2   <= '0;
      bus.uop_dst    <= '0;
    end else begin
      bus.uop_valid <= 1'b0;
      case (st)
        S_IDLE: if (ena) begin
          bus.rom_addr <= '0;
          flag_eq      <= 1'b0;
          rdy          <= 1'b0;
          st           <= S_FETCH;
        end
        S_FETCH: st <= S_DECODE;
        S_DECODE:
          if (op == OPCODE_RDY) st <= S_DONE;
          else if (!run) begin
            st <= last ? S_DONE : S_FETCH;
            if (!last) bus.rom_addr <= bus.rom_addr + 1'b1;
          end else begin
            bus.uop_opcode <= op;
            bus.uop_src1   <= w[SRC1_LSB+:4];
            bus.uop_src2   <= w[SRC2_LSB+:4];
            bus.uop_dst    <= w[DST_LSB+:4];
            bus.uop_valid  <= 1'b1;
            st             <= S_ISSUE;
          end
        S_ISSUE: st <= S_WAIT;
        S_WAIT:
          if (bus.uop_done) begin
            if (bus.uop_opcode == OPCODE_CMP) flag_eq <= bus.cmp_eq;
            st <= last ? S_DONE : S_FETCH;
            if (!last) bus.rom_addr <= bus.rom_addr + 1'b1;
          end else if (wd_to) st <= S_DONE;
        S_DONE: begin
          rdy <= 1'b1;
          st  <= S_IDLE;
        end
        default: st <= S_IDLE;
      endcase
    end
  end
`ifdef UOP_SEQ_WATCHDOG_EN
  uop_seq_watchdog u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (st == S_ISSUE),
    .inc     (st == S_WAIT),
    .expired (wd_to)
  );
  always_ff @(posedge clk)
    err <= rst ? 1'b0 : (err || (wd_to && !bus.uop_done));
`else
  assign wd_to = 1'b0;
  assign err   = 1'b0;
`endif
endmodule
